// File: rtl/axis_ifmap_pack_fifo.sv
// Ifmap staging FIFO: packs AXI-Stream beats into MAX_K x MAC_NUM entries of runtime
// height/width and presents the head entry height-interleaved to the MAC array.
module axis_ifmap_pack_fifo #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAC_NUM = 256,
    parameter int unsigned MAX_K   = 5,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    input  logic [11:0]                  cfg_channels,
    input  logic [2:0]                   cfg_kh,
    input  logic                         clear,
    input  logic                         rd_en,
    output logic                         out_valid,
    output logic [MAX_K*MAC_NUM-1:0]     ifmaps_out,
    output logic [$clog2(DEPTH):0]       fifo_cnt,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic                         err_tlast
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned NWORD  = MAC_NUM / DATA_W;
    localparam int unsigned WORD_W = $clog2(NWORD + 1);
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned CH_W   = 12;
    localparam int unsigned EXT_W  = 16;
    localparam int unsigned DSH    = $clog2(DATA_W);

    logic [MAC_NUM-1:0] mem [DEPTH][MAX_K];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [WORD_W-1:0] word_q;
    logic [ROW_W-1:0]  row_q;
    logic [CH_W-1:0]   ch_q;
    logic [ROW_W-1:0]  kh_q;

    logic [CH_W-1:0]   ch_cfg, ch_eff;
    logic [ROW_W-1:0]  kh_cfg, kh_eff;
    logic [EXT_W-1:0]  wpr, base;
    logic              first, last_word, last_row, done;
    logic              acc, commit, pop;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] beat_m;

    // Config sanitising; a fresh entry takes the live config, otherwise the latched one
    always_comb begin
        ch_cfg = cfg_channels;
        if (cfg_channels == '0 || cfg_channels > CH_W'(MAC_NUM))
            ch_cfg = CH_W'(MAC_NUM);
        kh_cfg = cfg_kh;
        if (cfg_kh == '0)
            kh_cfg = ROW_W'(1);
        else if (cfg_kh > ROW_W'(MAX_K))
            kh_cfg = ROW_W'(MAX_K);

        first  = (word_q == '0) && (row_q == '0);
        ch_eff = first ? ch_cfg : ch_q;
        kh_eff = first ? kh_cfg : kh_q;
        wpr    = EXT_W'((EXT_W'(ch_eff) + EXT_W'(DATA_W - 1)) >> DSH);

        last_word = (EXT_W'(word_q) + EXT_W'(1)) == wpr;
        last_row  = (EXT_W'(row_q) + EXT_W'(1)) == EXT_W'(kh_eff);
        done      = last_word && last_row;

        acc    = s_axis_tvalid && s_axis_tready && !clear;
        commit = acc && (done || s_axis_tlast);
        pop    = rd_en && !fifo_empty;

        cnt_d = fifo_cnt;
        if (commit && !pop)
            cnt_d = fifo_cnt + CNT_W'(1);
        else if (pop && !commit)
            cnt_d = fifo_cnt - CNT_W'(1);
    end

    // Channels at or beyond ch are forced to zero
    always_comb begin
        beat_m = '0;
        base   = EXT_W'(word_q) << DSH;
        for (int j = 0; j < DATA_W; j++)
            beat_m[j] = s_axis_tdata[j] && ((base + EXT_W'(j)) < EXT_W'(ch_eff));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            word_q        <= '0;
            row_q         <= '0;
            ch_q          <= CH_W'(MAC_NUM);
            kh_q          <= ROW_W'(1);
            fifo_cnt      <= '0;
            fifo_full     <= 1'b0;
            fifo_empty    <= 1'b1;
            out_valid     <= 1'b0;
            s_axis_tready <= 1'b1;
            err_tlast     <= 1'b0;
        end else if (clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            word_q        <= '0;
            row_q         <= '0;
            fifo_cnt      <= '0;
            fifo_full     <= 1'b0;
            fifo_empty    <= 1'b1;
            out_valid     <= 1'b0;
            s_axis_tready <= 1'b1;
            err_tlast     <= 1'b0;
        end else begin
            if (acc) begin
                if (first) begin
                    ch_q <= ch_cfg;
                    kh_q <= kh_cfg;
                end
                if (commit) begin
                    word_q <= '0;
                    row_q  <= '0;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end else if (last_word) begin
                    word_q <= '0;
                    row_q  <= row_q + ROW_W'(1);
                end else begin
                    word_q <= word_q + WORD_W'(1);
                end
                if (s_axis_tlast && !done)
                    err_tlast <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt      <= cnt_d;
            fifo_full     <= cnt_d == CNT_W'(DEPTH);
            fifo_empty    <= cnt_d == '0;
            out_valid     <= cnt_d != '0;
            s_axis_tready <= cnt_d != CNT_W'(DEPTH);
        end
    end

    // Entry storage; the first beat of an entry wipes stale rows before its own word lands
    always_ff @(posedge clk) begin
        if (acc) begin
            if (first)
                for (int h = 0; h < MAX_K; h++)
                    mem[wr_ptr][h] <= '0;
            for (int w = 0; w < NWORD; w++)
                if (word_q == WORD_W'(w))
                    mem[wr_ptr][row_q][w*DATA_W +: DATA_W] <= beat_m;
        end
    end

    // Height-interleaved head view, zero while nothing is committed
    always_comb begin
        ifmaps_out = '0;
        for (int h = 0; h < MAX_K; h++)
            for (int i = 0; i < MAC_NUM; i++)
                ifmaps_out[i*MAX_K + h] = out_valid && mem[rd_ptr][h][i];
    end

endmodule

// File: tb/tb_axis_ifmap_pack_fifo.sv
// Directed bench for axis_ifmap_pack_fifo: packing, masking, backpressure, wrap, early tlast, clear.
module tb_axis_ifmap_pack_fifo;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAC_NUM = 256;
    localparam int unsigned MAX_K   = 5;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned OUT_W   = MAX_K * MAC_NUM;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [DATA_W-1:0]  s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tlast;
    logic               s_axis_tready;
    logic [11:0]        cfg_channels;
    logic [2:0]         cfg_kh;
    logic               clear;
    logic               rd_en;
    logic               out_valid;
    logic [OUT_W-1:0]   ifmaps_out;
    logic [2:0]         fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               err_tlast;

    int n_cmp = 0;
    int n_bad = 0;

    axis_ifmap_pack_fifo #(
        .DATA_W(DATA_W), .MAC_NUM(MAC_NUM), .MAX_K(MAX_K), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .cfg_channels(cfg_channels), .cfg_kh(cfg_kh), .clear(clear), .rd_en(rd_en),
        .out_valid(out_valid), .ifmaps_out(ifmaps_out), .fifo_cnt(fifo_cnt),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row-major rows -> MAC-array interleaved view
    function automatic logic [OUT_W-1:0] ilv(input logic [MAX_K-1:0][MAC_NUM-1:0] r);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int h = 0; h < MAX_K; h++)
            for (int i = 0; i < MAC_NUM; i++)
                v[i*MAX_K + h] = r[h][i];
        return v;
    endfunction

    task automatic test_reset();
        logic [OUT_W-1:0] zero;
        zero = '0;
        rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        cfg_channels = 12'd256; cfg_kh = 3'd5; clear = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL reset_tready got=%b want=1", s_axis_tready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", fifo_cnt); end
        n_cmp++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_flags empty=%b full=%b want 1/0", fifo_empty, fifo_full); end
        n_cmp++; if (err_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_tlast); end
        n_cmp++; if (ifmaps_out !== zero) begin n_bad++; $display("FAIL reset_data %0d bits differ from zero", $countones(ifmaps_out ^ zero)); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd0 || fifo_empty !== 1'b1) begin n_bad++; $display("FAIL empty_pop cnt=%0d empty=%b want 0/1", fifo_cnt, fifo_empty); end
    endtask

    task automatic test_full_entry();
        logic [OUT_W-1:0] exp;
        logic [31:0] val;
        cfg_channels = 12'd256; cfg_kh = 3'd5;
        for (int n = 0; n < 40; n++) begin
            s_axis_tdata = 32'(n); s_axis_tvalid = 1'b1;
            tick();
            if (n == 38) begin
                n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL full_entry_early cnt=%0d want=0", fifo_cnt); end
            end
        end
        s_axis_tvalid = 1'b0;
        for (int h = 0; h < 5; h++)
            for (int i = 0; i < 256; i++) begin
                val = 32'(h*8 + i/32);
                exp[i*5 + h] = val[i%32];
            end
        n_cmp++; if (fifo_cnt !== 3'd1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL full_entry_cnt cnt=%0d valid=%b want 1/1", fifo_cnt, out_valid); end
        n_cmp++; if (ifmaps_out !== exp) begin n_bad++; $display("FAIL full_entry_data %0d bits differ", $countones(ifmaps_out ^ exp)); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL full_entry_pop cnt=%0d valid=%b want 0/0", fifo_cnt, out_valid); end
    endtask

    task automatic test_mask();
        logic [MAX_K-1:0][MAC_NUM-1:0] r;
        logic [OUT_W-1:0] exp;
        cfg_channels = 12'd40; cfg_kh = 3'd3;
        for (int n = 0; n < 6; n++) begin
            s_axis_tdata = 32'hFFFF_FFFF; s_axis_tvalid = 1'b1;
            tick();
            if (n == 4) begin
                n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL mask_early cnt=%0d want=0", fifo_cnt); end
            end
        end
        s_axis_tvalid = 1'b0;
        r = '0;
        for (int h = 0; h < 3; h++) r[h][39:0] = '1;
        exp = ilv(r);
        n_cmp++; if (fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL mask_cnt got=%0d want=1", fifo_cnt); end
        n_cmp++; if (ifmaps_out !== exp) begin n_bad++; $display("FAIL mask_data %0d bits differ", $countones(ifmaps_out ^ exp)); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [MAX_K-1:0][MAC_NUM-1:0] r;
        logic [OUT_W-1:0] exp;
        cfg_channels = 12'd32; cfg_kh = 3'd1;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_axis_tdata = 32'h100 + 32'(k);
            tick();
        end
        n_cmp++; if (fifo_cnt !== 3'd4 || fifo_full !== 1'b1) begin n_bad++; $display("FAIL bp_full cnt=%0d full=%b want 4/1", fifo_cnt, fifo_full); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL bp_tready got=%b want=0", s_axis_tready); end
        s_axis_tdata = 32'h1FF;
        tick();
        n_cmp++; if (fifo_cnt !== 3'd4) begin n_bad++; $display("FAIL bp_hold cnt=%0d want=4", fifo_cnt); end
        s_axis_tvalid = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd3 || s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL bp_pop cnt=%0d tready=%b want 3/1", fifo_cnt, s_axis_tready); end
        r = '0; r[0][31:0] = 32'h101; exp = ilv(r);
        n_cmp++; if (ifmaps_out !== exp) begin n_bad++; $display("FAIL bp_head %0d bits differ", $countones(ifmaps_out ^ exp)); end
    endtask

    task automatic test_back_to_back();
        logic [MAX_K-1:0][MAC_NUM-1:0] r;
        logic [OUT_W-1:0] exp;
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd2) begin n_bad++; $display("FAIL b2b_pre cnt=%0d want=2", fifo_cnt); end
        rd_en = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h104;
        tick();
        rd_en = 1'b0; s_axis_tvalid = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd2) begin n_bad++; $display("FAIL b2b_cnt cnt=%0d want=2", fifo_cnt); end
        r = '0; r[0][31:0] = 32'h103; exp = ilv(r);
        n_cmp++; if (ifmaps_out !== exp) begin n_bad++; $display("FAIL b2b_head0 %0d bits differ", $countones(ifmaps_out ^ exp)); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        r = '0; r[0][31:0] = 32'h104; exp = ilv(r);
        n_cmp++; if (ifmaps_out !== exp || fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL b2b_head1 %0d bits differ cnt=%0d want 1", $countones(ifmaps_out ^ exp), fifo_cnt); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_cmp++; if (fifo_empty !== 1'b1 || fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL b2b_drain empty=%b cnt=%0d want 1/0", fifo_empty, fifo_cnt); end
    endtask

    task automatic test_early_tlast();
        logic [MAX_K-1:0][MAC_NUM-1:0] r;
        logic [OUT_W-1:0] exp;
        cfg_channels = 12'd64; cfg_kh = 3'd5;
        for (int n = 0; n < 4; n++) begin
            s_axis_tdata = 32'hC0DE_0000 + 32'(n); s_axis_tvalid = 1'b1; s_axis_tlast = (n == 3);
            tick();
            if (n == 2) begin
                n_cmp++; if (fifo_cnt !== 3'd0 || err_tlast !== 1'b0) begin n_bad++; $display("FAIL tlast_pre cnt=%0d err=%b want 0/0", fifo_cnt, err_tlast); end
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        r = '0;
        r[0][63:0] = {32'hC0DE_0001, 32'hC0DE_0000};
        r[1][63:0] = {32'hC0DE_0003, 32'hC0DE_0002};
        exp = ilv(r);
        n_cmp++; if (fifo_cnt !== 3'd1 || err_tlast !== 1'b1) begin n_bad++; $display("FAIL tlast_commit cnt=%0d err=%b want 1/1", fifo_cnt, err_tlast); end
        n_cmp++; if (ifmaps_out !== exp) begin n_bad++; $display("FAIL tlast_data %0d bits differ", $countones(ifmaps_out ^ exp)); end
        cfg_kh = 3'd1;
        clear = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD;
        tick();
        clear = 1'b0;
        n_cmp++; if (err_tlast !== 1'b0 || fifo_cnt !== 3'd0 || fifo_empty !== 1'b1) begin n_bad++; $display("FAIL clear err=%b cnt=%0d empty=%b want 0/0/1", err_tlast, fifo_cnt, fifo_empty); end
        s_axis_tdata = 32'h1111;
        tick();
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL clear_drop cnt=%0d want=0", fifo_cnt); end
        s_axis_tdata = 32'h2222;
        tick();
        s_axis_tvalid = 1'b0;
        r = '0; r[0][63:0] = {32'h2222, 32'h1111}; exp = ilv(r);
        n_cmp++; if (fifo_cnt !== 3'd1 || ifmaps_out !== exp) begin n_bad++; $display("FAIL clear_refill cnt=%0d want 1, %0d bits differ", fifo_cnt, $countones(ifmaps_out ^ exp)); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_cfg_latch();
        logic [MAX_K-1:0][MAC_NUM-1:0] r;
        logic [OUT_W-1:0] exp;
        cfg_channels = 12'd32; cfg_kh = 3'd5;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n == 2) cfg_kh = 3'd2;
            s_axis_tdata = 32'h10 + 32'(n);
            tick();
            if (n == 3) begin
                n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL latch_mid cnt=%0d want=0", fifo_cnt); end
            end
        end
        n_cmp++; if (fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL latch_commit cnt=%0d want=1", fifo_cnt); end
        for (int n = 0; n < 2; n++) begin
            s_axis_tdata = 32'h20 + 32'(n);
            tick();
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (fifo_cnt !== 3'd2) begin n_bad++; $display("FAIL latch_next cnt=%0d want=2", fifo_cnt); end
        r = '0;
        for (int h = 0; h < 5; h++) r[h][31:0] = 32'h10 + 32'(h);
        exp = ilv(r);
        n_cmp++; if (ifmaps_out !== exp) begin n_bad++; $display("FAIL latch_data0 %0d bits differ", $countones(ifmaps_out ^ exp)); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        r = '0; r[0][31:0] = 32'h20; r[1][31:0] = 32'h21; exp = ilv(r);
        n_cmp++; if (ifmaps_out !== exp) begin n_bad++; $display("FAIL latch_data1 %0d bits differ", $countones(ifmaps_out ^ exp)); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        logic [MAX_K-1:0][MAC_NUM-1:0] r;
        logic [OUT_W-1:0] exp;
        logic [OUT_W-1:0] zero;
        zero = '0;
        cfg_channels = 12'd32; cfg_kh = 3'd2;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h30;
        tick();
        s_axis_tvalid = 1'b0;
        rst_n = 1'b0; #3; rst_n = 1'b1;
        n_cmp++; if (fifo_cnt !== 3'd0 || ifmaps_out !== zero || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid cnt=%0d valid=%b want 0/0", fifo_cnt, out_valid); end
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h31;
        tick();
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_restart cnt=%0d want=0", fifo_cnt); end
        s_axis_tdata = 32'h32;
        tick();
        s_axis_tvalid = 1'b0;
        r = '0; r[0][31:0] = 32'h31; r[1][31:0] = 32'h32; exp = ilv(r);
        n_cmp++; if (fifo_cnt !== 3'd1 || ifmaps_out !== exp) begin n_bad++; $display("FAIL rst_refill cnt=%0d want 1, %0d bits differ", fifo_cnt, $countones(ifmaps_out ^ exp)); end
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_mask();
        test_backpressure();
        test_back_to_back();
        test_early_tlast();
        test_cfg_latch();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
